// File: rtl/seq_shifter2x4_if.sv
// Request/result bus of the two-lane sequential shifter.
// The master drives requests and result acceptance; the slave is the shifter.
interface seq_shifter2x4_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       amt;
  logic             dir;
  logic             arith;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ya;
  logic [WIDTH-1:0] yb;
  logic             busy;

  modport master (
    output in_valid, a, b, amt, dir, arith, out_ready,
    input  in_ready, out_valid, ya, yb, busy
  );

  modport slave (
    input  in_valid, a, b, amt, dir, arith, out_ready,
    output in_ready, out_valid, ya, yb, busy
  );
endinterface

// File: rtl/seq_shifter2x4.sv
// Two-lane sequential shifter: both lanes move one bit per cycle for amt cycles,
// then hold the result until the consumer takes it.
module seq_shifter2x4 #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  seq_shifter2x4_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [2:0]       cnt_r;
  logic [2:0]       cnt_nxt_s;
  logic [WIDTH-1:0] lane_a_r;
  logic [WIDTH-1:0] lane_a_nxt_s;
  logic [WIDTH-1:0] lane_b_r;
  logic [WIDTH-1:0] lane_b_nxt_s;
  logic             dir_r;
  logic             dir_nxt_s;
  logic             arith_r;
  logic             arith_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  // One-position shift; arithmetic fill only applies when moving right.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] lane,
    input logic             go_right,
    input logic             sign_fill
  );
    logic [WIDTH-1:0] res;
    if (go_right) begin
      res = {sign_fill & lane[WIDTH-1], lane[WIDTH-1:1]};
    end else begin
      res = {lane[WIDTH-2:0], 1'b0};
    end
    return res;
  endfunction

  // Next-state, counter and lane update logic.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    lane_a_nxt_s = lane_a_r;
    lane_b_nxt_s = lane_b_r;
    dir_nxt_s    = dir_r;
    arith_nxt_s  = arith_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          lane_a_nxt_s = bus.a;
          lane_b_nxt_s = bus.b;
          dir_nxt_s    = bus.dir;
          arith_nxt_s  = bus.arith;
          cnt_nxt_s    = bus.amt;
          if (bus.amt == 3'd0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        lane_a_nxt_s = shift_step(lane_a_r, dir_r, arith_r);
        lane_b_nxt_s = shift_step(lane_b_r, dir_r, arith_r);
        cnt_nxt_s    = cnt_r - 3'd1;
        if (cnt_r == 3'd1) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // State and datapath registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      lane_a_r    <= '0;
      lane_b_r    <= '0;
      dir_r       <= 1'b0;
      arith_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      lane_a_r    <= lane_a_nxt_s;
      lane_b_r    <= lane_b_nxt_s;
      dir_r       <= dir_nxt_s;
      arith_r     <= arith_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.ya        = lane_a_r;
  assign bus.yb        = lane_b_r;

endmodule
